// File: rtl/rmt_pkg.sv
// Shared constants and state encoding for the rename-map-table decode stage.
package rmt_pkg;

  localparam int SRAM_DEPTH_DEF   = 64;
  localparam int SRAM_INDEX_DEF   = 6;
  localparam int SRAM_WIDTH_DEF   = 8;
  localparam int INIT_ENTRIES_DEF = 32;
  localparam int NUM_RD_PORTS     = 8;
  localparam int NUM_WR_PORTS     = 4;

  typedef enum logic {
    INIT,
    RUN
  } state_e;

endpackage

// File: rtl/onehot_dec.sv
// Combinational binary-to-one-hot decoder; out-of-range indices give an all-zero bus.
module onehot_dec #(
  parameter int SRAM_DEPTH = 64,
  parameter int SRAM_INDEX = 6
) (
  input  logic [SRAM_INDEX-1:0] idx,
  output logic [SRAM_DEPTH-1:0] onehot
);

  always_comb begin
    onehot = '0;
    for (int i = 0; i < SRAM_DEPTH; i++) begin
      onehot[i] = (idx == SRAM_INDEX'(i));
    end
  end

endmodule

// File: rtl/rmt_decode_stage.sv
// Decode/register stage in front of the rename map SRAM, with post-reset identity-map init.
// Optional build macro RMT_WAW_SQUASH_EN keeps only the highest enabled write port per target entry.
module rmt_decode_stage
  import rmt_pkg::*;
#(
  parameter int SRAM_DEPTH   = SRAM_DEPTH_DEF,
  parameter int SRAM_INDEX   = SRAM_INDEX_DEF,
  parameter int SRAM_WIDTH   = SRAM_WIDTH_DEF,
  parameter int INIT_ENTRIES = INIT_ENTRIES_DEF
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  valid_i,
  input  logic                  stall_i,
  input  logic                  flush_i,
  input  logic [SRAM_INDEX-1:0] rd_addr0_i, rd_addr1_i, rd_addr2_i, rd_addr3_i,
  input  logic [SRAM_INDEX-1:0] rd_addr4_i, rd_addr5_i, rd_addr6_i, rd_addr7_i,
  input  logic [SRAM_INDEX-1:0] wr_addr0_i, wr_addr1_i, wr_addr2_i, wr_addr3_i,
  input  logic [SRAM_WIDTH-1:0] wr_data0_i, wr_data1_i, wr_data2_i, wr_data3_i,
  input  logic                  wr_en0_i, wr_en1_i, wr_en2_i, wr_en3_i,
  output logic                  init_done_o,
  output logic [SRAM_DEPTH-1:0] decoded_addr0_o, decoded_addr1_o, decoded_addr2_o, decoded_addr3_o,
  output logic [SRAM_DEPTH-1:0] decoded_addr4_o, decoded_addr5_o, decoded_addr6_o, decoded_addr7_o,
  output logic [SRAM_DEPTH-1:0] decoded_addr0wr_o, decoded_addr1wr_o, decoded_addr2wr_o, decoded_addr3wr_o,
  output logic                  we0_o, we1_o, we2_o, we3_o,
  output logic [SRAM_WIDTH-1:0] data0wr_o, data1wr_o, data2wr_o, data3wr_o
);

  localparam int INIT_GROUPS = INIT_ENTRIES / 4;
  localparam int CNT_W       = (INIT_GROUPS > 1) ? $clog2(INIT_GROUPS) : 1;
  localparam logic [CNT_W-1:0] LAST_GROUP = CNT_W'(INIT_GROUPS - 1);

  logic [SRAM_INDEX-1:0] rd_addr [NUM_RD_PORTS];
  logic [SRAM_INDEX-1:0] wr_addr [NUM_WR_PORTS];
  logic [SRAM_WIDTH-1:0] wr_data [NUM_WR_PORTS];
  logic [NUM_WR_PORTS-1:0] wr_en;

  assign rd_addr = '{rd_addr0_i, rd_addr1_i, rd_addr2_i, rd_addr3_i,
                     rd_addr4_i, rd_addr5_i, rd_addr6_i, rd_addr7_i};
  assign wr_addr = '{wr_addr0_i, wr_addr1_i, wr_addr2_i, wr_addr3_i};
  assign wr_data = '{wr_data0_i, wr_data1_i, wr_data2_i, wr_data3_i};
  assign wr_en   = {wr_en3_i, wr_en2_i, wr_en1_i, wr_en0_i};

  logic [SRAM_DEPTH-1:0] rd_dec [NUM_RD_PORTS];
  logic [SRAM_DEPTH-1:0] wr_dec [NUM_WR_PORTS];

  for (genvar n = 0; n < NUM_RD_PORTS; n++) begin : g_rd_dec
    onehot_dec #(.SRAM_DEPTH(SRAM_DEPTH), .SRAM_INDEX(SRAM_INDEX)) u_dec (
      .idx(rd_addr[n]), .onehot(rd_dec[n])
    );
  end

  for (genvar k = 0; k < NUM_WR_PORTS; k++) begin : g_wr_dec
    onehot_dec #(.SRAM_DEPTH(SRAM_DEPTH), .SRAM_INDEX(SRAM_INDEX)) u_dec (
      .idx(wr_addr[k]), .onehot(wr_dec[k])
    );
  end

  state_e                  state_q, state_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic                    done_q, done_d;
  logic [SRAM_DEPTH-1:0]   rd_q [NUM_RD_PORTS];
  logic [SRAM_DEPTH-1:0]   rd_d [NUM_RD_PORTS];
  logic [SRAM_DEPTH-1:0]   wr_q [NUM_WR_PORTS];
  logic [SRAM_DEPTH-1:0]   wr_d [NUM_WR_PORTS];
  logic [SRAM_WIDTH-1:0]   data_q [NUM_WR_PORTS];
  logic [SRAM_WIDTH-1:0]   data_d [NUM_WR_PORTS];
  logic [NUM_WR_PORTS-1:0] we_q, we_d;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= INIT;
      cnt_q   <= '0;
      done_q  <= 1'b0;
      rd_q    <= '{default: '0};
      wr_q    <= '{default: '0};
      data_q  <= '{default: '0};
      we_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
      rd_q    <= rd_d;
      wr_q    <= wr_d;
      data_q  <= data_d;
      we_q    <= we_d;
    end
  end

  // Bundles are only taken once init_done_o is visible, so the first RUN edge is a bubble.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    done_d  = done_q;
    rd_d    = rd_q;
    wr_d    = wr_q;
    data_d  = data_q;
    we_d    = we_q;
    case (state_q)
      INIT: begin
        for (int n = 0; n < NUM_RD_PORTS; n++) rd_d[n] = '0;
        for (int k = 0; k < NUM_WR_PORTS; k++) begin
          for (int j = 0; j < SRAM_DEPTH; j++) begin
            wr_d[k][j] = (j == 4 * int'(cnt_q) + k);
          end
          data_d[k] = SRAM_WIDTH'(4 * int'(cnt_q) + k);
          we_d[k]   = 1'b1;
        end
        if (cnt_q == LAST_GROUP) state_d = RUN;
        else                     cnt_d   = cnt_q + CNT_W'(1);
      end
      RUN: begin
        done_d = 1'b1;
        if (flush_i) begin
          rd_d = '{default: '0};
          wr_d = '{default: '0};
          we_d = '0;
        end else if (stall_i && done_q) begin
          we_d = we_q;
        end else if (valid_i && done_q) begin
          rd_d   = rd_dec;
          wr_d   = wr_dec;
          data_d = wr_data;
          we_d   = wr_en;
`ifdef RMT_WAW_SQUASH_EN
          for (int j = 0; j < NUM_WR_PORTS - 1; j++) begin
            for (int k = j + 1; k < NUM_WR_PORTS; k++) begin
              if (wr_en[k] && (wr_addr[k] == wr_addr[j])) we_d[j] = 1'b0;
            end
          end
`endif
        end else begin
          rd_d   = '{default: '0};
          wr_d   = '{default: '0};
          data_d = '{default: '0};
          we_d   = '0;
        end
      end
      default: state_d = INIT;
    endcase
  end

  // A held write must not repeat into the SRAM while the stall persists.
  logic stall_gate;
  assign stall_gate = stall_i & done_q;

  assign init_done_o       = done_q;
  assign decoded_addr0_o   = rd_q[0];
  assign decoded_addr1_o   = rd_q[1];
  assign decoded_addr2_o   = rd_q[2];
  assign decoded_addr3_o   = rd_q[3];
  assign decoded_addr4_o   = rd_q[4];
  assign decoded_addr5_o   = rd_q[5];
  assign decoded_addr6_o   = rd_q[6];
  assign decoded_addr7_o   = rd_q[7];
  assign decoded_addr0wr_o = wr_q[0];
  assign decoded_addr1wr_o = wr_q[1];
  assign decoded_addr2wr_o = wr_q[2];
  assign decoded_addr3wr_o = wr_q[3];
  assign data0wr_o         = data_q[0];
  assign data1wr_o         = data_q[1];
  assign data2wr_o         = data_q[2];
  assign data3wr_o         = data_q[3];
  assign we0_o             = we_q[0] & ~stall_gate;
  assign we1_o             = we_q[1] & ~stall_gate;
  assign we2_o             = we_q[2] & ~stall_gate;
  assign we3_o             = we_q[3] & ~stall_gate;

endmodule
